// File: rtl/rom_tx_sequencer_pkg.sv
// Shared definitions for the ROM-to-UART message sequencer: default widths and FSM state type.
package rom_tx_sequencer_pkg;

  localparam int unsigned DefAddrWidth = 5;
  localparam int unsigned DefDataWidth = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFetch    = 3'd1,
    StLatch    = 3'd2,
    StSend     = 3'd3,
    StWaitBusy = 3'd4,
    StWaitDone = 3'd5,
    StFin      = 3'd6
  } seq_state_e;

endpackage

// File: rtl/rom_tx_sequencer.sv
// Streams a commanded run of cmd_len ROM bytes starting at cmd_base into uart_tx,
// handing each byte over only when the transmitter reports ready.
module rom_tx_sequencer
  import rom_tx_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter bit          STOP_ON_NUL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   sent_cnt
);

  localparam logic [ADDR_WIDTH:0]   CntOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   sent_cnt_q, sent_cnt_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sent_cnt_d = sent_cnt_q;
    rom_addr_d = rom_addr_q;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    tx_start   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          len_d      = cmd_len;
          rom_addr_d = cmd_base;
          sent_cnt_d = '0;
          state_d    = (cmd_len == '0) ? StFin : StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        tx_data_d = rom_data;
        state_d   = (STOP_ON_NUL && (rom_data == '0)) ? StFin : StSend;
      end
      StSend: begin
        // Start is gated by ready in the same cycle so it can never fire into a busy transmitter.
        if (tx_ready) begin
          tx_start   = 1'b1;
          sent_cnt_d = sent_cnt_q + CntOne;
          rom_addr_d = rom_addr_q + AddrOne;
          state_d    = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (!tx_ready) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (tx_ready) state_d = (sent_cnt_q == len_q) ? StFin : StFetch;
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      sent_cnt_q <= '0;
      rom_addr_q <= '0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sent_cnt_q <= sent_cnt_d;
      rom_addr_q <= rom_addr_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign rom_addr  = rom_addr_q;
  assign tx_data   = tx_data_q;
  assign sent_cnt  = sent_cnt_q;

endmodule
